// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction sequencer issuing load/store/accumulate commands with repeat support
module instr_sequencer #(
    parameter int OPCODE_W   = 3,
    parameter int ADDR_W     = 7,
    parameter int MEM_HEIGHT = 16,
    parameter int REP_W      = 4,
    localparam int INSTR_W   = OPCODE_W + ADDR_W,
    localparam int WA_W      = (MEM_HEIGHT > 1) ? $clog2(MEM_HEIGHT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic               req_vld,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_ack,
    output logic               write_en,
    output logic [WA_W-1:0]    wr_addr,
    output logic               input_valid,
    output logic               accumulate_internal,
    output logic               done,
    output logic               illegal
);

    localparam logic [OPCODE_W-1:0] OP_NOP    = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_REPEAT = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_ACC0   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_ACCI   = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_STOP   = OPCODE_W'(7);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_WAIT_LOAD = 2'd1,
        S_REPEAT    = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t state, state_next;

    logic [REP_W-1:0]   rep_cnt;
    logic [REP_W-1:0]   rem;
    logic [INSTR_W-1:0] held;

    logic [OPCODE_W-1:0] in_op;
    logic [ADDR_W-1:0]   in_opd;
    logic                accept;
    logic                ack_ok;

    logic                issue;
    logic                issue_first;
    logic [INSTR_W-1:0]  iss_instr;
    logic [OPCODE_W-1:0] iss_op;
    logic [ADDR_W-1:0]   iss_opd;
    logic                iss_reserved;

    logic                req_vld_d;
    logic [ADDR_W-1:0]   rd_addr_d;
    logic                write_en_d;
    logic [WA_W-1:0]     wr_addr_d;
    logic                input_valid_d;
    logic                acc_int_d;
    logic                illegal_d;
    logic                done_d;

    assign in_op       = instr[INSTR_W-1:ADDR_W];
    assign in_opd      = instr[ADDR_W-1:0];
    assign instr_ready = (state == S_RUN);
    assign accept      = instr_valid && instr_ready;
    // An ack in the same cycle as the request pulse belongs to no load yet.
    assign ack_ok      = (state == S_WAIT_LOAD) && rd_ack && !req_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (accept) begin
                    if (in_op == OP_STOP) begin
                        state_next = S_DONE;
                    end else if (in_op == OP_LOAD) begin
                        state_next = S_WAIT_LOAD;
                    end else if (in_op != OP_REPEAT && rep_cnt != '0) begin
                        state_next = S_REPEAT;
                    end
                end
            end
            S_WAIT_LOAD: begin
                if (ack_ok) begin
                    state_next = (rem != '0) ? S_REPEAT : S_RUN;
                end
            end
            S_REPEAT: begin
                if (held[INSTR_W-1:ADDR_W] == OP_LOAD) begin
                    state_next = S_WAIT_LOAD;
                end else if (rem == REP_W'(1)) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_DONE;
        endcase
    end

    // Decode of the instruction being issued this cycle; registered below.
    always_comb begin
        issue       = 1'b0;
        issue_first = 1'b0;
        iss_instr   = held;
        if (accept && in_op != OP_REPEAT) begin
            issue       = 1'b1;
            issue_first = 1'b1;
            iss_instr   = instr;
        end else if (state == S_REPEAT) begin
            issue = 1'b1;
        end
        iss_op       = iss_instr[INSTR_W-1:ADDR_W];
        iss_opd      = iss_instr[ADDR_W-1:0];
        iss_reserved = !(iss_op inside {OP_NOP, OP_STORE, OP_LOAD, OP_REPEAT,
                                        OP_ACC0, OP_ACCI, OP_STOP});

        req_vld_d     = issue && (iss_op == OP_LOAD);
        rd_addr_d     = req_vld_d ? iss_opd : '0;
        write_en_d    = issue && (iss_op == OP_STORE);
        wr_addr_d     = write_en_d ? iss_opd[WA_W-1:0] : '0;
        input_valid_d = issue && (iss_op == OP_ACC0 || iss_op == OP_ACCI);
        acc_int_d     = issue && (iss_op == OP_ACCI);
        illegal_d     = issue && issue_first && iss_reserved;
        done_d        = done || (issue && iss_op == OP_STOP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt             <= '0;
            rem                 <= '0;
            held                <= '0;
            req_vld             <= 1'b0;
            rd_addr             <= '0;
            write_en            <= 1'b0;
            wr_addr             <= '0;
            input_valid         <= 1'b0;
            accumulate_internal <= 1'b0;
            illegal             <= 1'b0;
            done                <= 1'b0;
        end else begin
            if (accept) begin
                if (in_op == OP_REPEAT) begin
                    rep_cnt <= in_opd[REP_W-1:0];
                end else begin
                    rep_cnt <= '0;
                    rem     <= rep_cnt;
                    held    <= instr;
                end
            end else if (state == S_REPEAT) begin
                rem <= rem - REP_W'(1);
            end
            req_vld             <= req_vld_d;
            rd_addr             <= rd_addr_d;
            write_en            <= write_en_d;
            wr_addr             <= wr_addr_d;
            input_valid         <= input_valid_d;
            accumulate_internal <= acc_int_d;
            illegal             <= illegal_d;
            done                <= done_d;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with random program and ack responder
module tb_instr_sequencer;

    localparam int INSTR_W = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [INSTR_W-1:0] instr = '0;
    logic               instr_valid = 1'b0;
    logic               instr_ready;
    logic               req_vld;
    logic [6:0]         rd_addr;
    logic               rd_ack = 1'b0;
    logic               write_en;
    logic [3:0]         wr_addr;
    logic               input_valid;
    logic               accumulate_internal;
    logic               done;
    logic               illegal;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .req_vld(req_vld), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .write_en(write_en), .wr_addr(wr_addr),
        .input_valid(input_valid), .accumulate_internal(accumulate_internal),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          rep_m = 0;
    bit          stopped = 1'b0;
    int          stop_cyc = 0;
    bit          auto_ack = 1'b0;
    logic [15:0] mon_act;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a repeat count n makes the next instruction happen n+1 times.
    task automatic model_accept(input logic [INSTR_W-1:0] w);
        logic [2:0]  op;
        logic [6:0]  opd;
        logic [15:0] e;
        int          n;
        op  = w[9:7];
        opd = w[6:0];
        if (op == 3'b011) begin
            rep_m = int'(opd[3:0]);
            return;
        end
        if (op == 3'b111) begin
            stopped  = 1'b1;
            stop_cyc = cyc;
            rep_m    = 0;
            return;
        end
        n     = rep_m + 1;
        rep_m = 0;
        for (int k = 0; k < n; k++) begin
            case (op)
                3'b001:  e = {8'd0, 1'b1, opd[3:0], 3'b000};
                3'b010:  e = {1'b1, opd, 8'd0};
                3'b100:  e = 16'h0004;
                3'b110:  e = 16'h0006;
                3'b101:  e = (k == 0) ? 16'h0001 : 16'h0000;
                default: e = 16'h0000;
            endcase
            if (e != 16'h0000) exp_q.push_back(e);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        rep_m   = 0;
        stopped = 1'b0;
    endtask

    task automatic send(input logic [INSTR_W-1:0] w);
        int n;
        n = 0;
        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout instr=%h ready=0 required=1", w);
            instr_valid = 1'b0;
            return;
        end
        model_accept(w);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst         = 1'b1;
        instr_valid = 1'b0;
        clear_model();
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({req_vld, rd_addr, write_en, wr_addr, input_valid,
                    accumulate_internal, done, illegal});
    endfunction

    // Monitor: pops one expected command for every cycle the DUT shows a command.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_act = {req_vld, rd_addr, write_en, wr_addr, input_valid,
                           accumulate_internal, illegal};
                if (req_vld || write_en || input_valid || illegal) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected actual=%h required=none", mon_act);
                    end else begin
                        check("sb_cmd", 32'(mon_act), 32'(exp_q.pop_front()));
                    end
                end
                check("done_level", 32'(done), 32'(stopped && cyc > stop_cyc));
            end
        end
    end

    // Load responder: sometimes acks alongside req_vld (must be ignored), then acks 1-4 cycles later.
    initial begin
        int d;
        d = -1;
        forever begin
            @(negedge clk);
            if (auto_ack) begin
                rd_ack = 1'b0;
                if (rst) begin
                    d = -1;
                end else if (req_vld) begin
                    rd_ack = 1'($urandom_range(0, 1));
                    d      = int'($urandom_range(1, 4));
                end else if (d > 1) begin
                    d--;
                end else if (d == 1) begin
                    rd_ack = 1'b1;
                    d      = -1;
                end else begin
                    rd_ack = ($urandom_range(0, 7) == 0);
                end
            end
        end
    end

    initial begin
        int lo;
        int rdy;
        int r;
        int wait_n;
        logic [2:0] op;
        logic [2:0] ops [6];
        ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        #2 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(instr_ready), 1);

        send(10'b001_0010011);
        check("store_we", 32'(write_en), 1);
        check("store_wa", 32'(wr_addr), 3);
        check("store_other", 32'({req_vld, input_valid, illegal, done}), 0);
        @(posedge clk); #1;
        check("store_pulse", 32'(write_en), 0);

        send(10'b010_0000101);
        check("load_req", 32'(req_vld), 1);
        check("load_addr", 32'(rd_addr), 5);
        rd_ack = 1'b1;
        @(posedge clk); #1;
        rd_ack = 1'b0;
        check("load_pulse", 32'(req_vld), 0);
        check("load_coincident_ack_ignored", 32'(instr_ready), 0);
        repeat (3) begin @(posedge clk); #1; end
        check("load_wait_ready", 32'(instr_ready), 0);
        rd_ack = 1'b1;
        @(posedge clk); #1;
        rd_ack = 1'b0;
        check("load_ready_after_ack", 32'(instr_ready), 1);

        send(10'b011_0000011);
        send(10'b110_0000000);
        lo = 0;
        for (int i = 0; i < 4; i++) begin
            check("repeat_acc_issue", 32'(input_valid && accumulate_internal), 1);
            if (!instr_ready) lo++;
            @(posedge clk); #1;
        end
        check("repeat_acc_end", 32'(input_valid), 0);
        check("repeat_ready_low", 32'(lo), 3);

        send(10'b101_1010101);
        check("reserved_illegal", 32'(illegal), 1);
        check("reserved_no_cmd", 32'({req_vld, write_en, input_valid}), 0);
        @(posedge clk); #1;
        check("reserved_pulse", 32'(illegal), 0);

        send(10'b010_0001111);
        rst = 1'b1;
        #1;
        check("rst_wait_load_outs", all_outs(), 0);
        clear_model();
        @(negedge clk); #2 rst = 1'b0;
        send(10'b001_0000111);
        check("after_rst_load_store", 32'({write_en, wr_addr}), 32'h17);

        send(10'b011_0000101);
        send(10'b100_0000000);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_repeat_outs", all_outs(), 0);
        clear_model();
        @(negedge clk); #2 rst = 1'b0;
        send(10'b110_0000000);
        check("after_rst_rep_issue", 32'(input_valid && accumulate_internal), 1);
        @(posedge clk); #1;
        check("after_rst_rep_single", 32'(input_valid), 0);

        send(10'b011_0000011);
        send(10'b111_0000000);
        check("stop_done", 32'(done), 1);
        instr       = 10'b001_0000001;
        instr_valid = 1'b1;
        rdy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (instr_ready || !done) rdy++;
        end
        check("stop_held", 32'(rdy), 0);
        do_reset();

        auto_ack = 1'b1;
        for (int t = 0; t < 400; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                send({3'b111, 7'($urandom)});
                repeat (3) @(negedge clk);
                do_reset();
            end else if (r < 20) begin
                send({3'b011, 7'($urandom)});
            end else if (r < 23) begin
                do_reset();
            end else begin
                op = ops[$urandom_range(0, 5)];
                send({op, 7'($urandom)});
            end
        end
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 500) begin
            @(negedge clk);
            wait_n++;
        end
        repeat (5) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 3, opcode field width (instruction MSBs).
REQ-002 Parameter ADDR_W, default 7, operand field width (instruction LSBs); instruction width INSTR_W = OPCODE_W + ADDR_W.
REQ-003 Parameter MEM_HEIGHT, default 16, internal memory depth; wr_addr width WA_W = clog2(MEM_HEIGHT).
REQ-004 Parameter REP_W, default 4, repeat counter width.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 instr  input  INSTR_W  instruction word.
REQ-008 instr_valid  input  1  instr is valid.
REQ-009 instr_ready  output  1  sequencer accepts instr this cycle.
REQ-010 req_vld  output  1  load request pulse to load unit.
REQ-011 rd_addr  output  ADDR_W  load address.
REQ-012 rd_ack  input  1  load unit completed outstanding load.
REQ-013 write_en  output  1  store to internal memory.
REQ-014 wr_addr  output  WA_W  store address.
REQ-015 input_valid  output  1  accumulator input valid.
REQ-016 accumulate_internal  output  1  accumulate with internal operand (0 = accumulate zero).
REQ-017 done  output  1  layer stopped, level signal.
REQ-018 illegal  output  1  one-cycle pulse on reserved opcode.

Function
REQ-019 Opcodes (OPCODE_W=3): 000 NOP, 001 store, 010 load, 011 repeat, 100 acc-0, 110 acc-internal, 111 stop, 101 reserved.
REQ-020 Handshake: instruction accepted on rising edge where instr_valid && instr_ready; instr_ready is combinational from state only (RUN and not stalled), never from instr_valid.
REQ-021 All command outputs registered: accepted instruction drives its outputs exactly one cycle after acceptance, for exactly one cycle; otherwise all command outputs 0.
REQ-022 Store: write_en=1, wr_addr = operand[WA_W-1:0] (upper bits ignored).
REQ-023 Load: req_vld=1, rd_addr = operand; FSM enters WAIT_LOAD.
REQ-024 Acc-0: input_valid=1, accumulate_internal=0; acc-internal: input_valid=1, accumulate_internal=1.
REQ-025 Repeat: loads counter with operand[REP_W-1:0]; no command output; next accepted instruction is issued counter+1 times on consecutive cycles (state REPEAT), instr_ready=0 during the extra issues.
REQ-026 Repeat operand 0 behaves as NOP-equivalent single issue; repeat following repeat overwrites the counter.
REQ-027 Repeated load: each issue waits in WAIT_LOAD for rd_ack before the next issue.
REQ-028 Reserved opcode: treated as NOP plus illegal=1 for one cycle; wider OPCODE_W values not listed are reserved.
REQ-029 Stop: done=1 from the cycle after acceptance, held until reset; FSM enters DONE, instr_ready=0.
REQ-030 FSM states RUN (reset state), WAIT_LOAD, REPEAT, DONE; RUN->WAIT_LOAD on load; WAIT_LOAD->RUN (or REPEAT if count remains) on rd_ack; RUN->REPEAT on instruction following repeat with count>0; REPEAT->RUN when count reaches 0; any->DONE on accepted stop.
REQ-031 WAIT_LOAD: instr_ready=0; rd_ack arriving in the same cycle as req_vld is ignored (ack only counted from the cycle after req_vld).
REQ-032 rd_ack while not in WAIT_LOAD is ignored.
REQ-033 Stop or repeat cannot themselves be repeated: a repeat applied to stop issues stop once.

Reset
REQ-034 rst asserted: FSM to RUN, repeat counter 0, all outputs 0 except instr_ready, which becomes 1 once rst deasserts; mid-load or mid-repeat, pending work is discarded.
REQ-035 First instruction accepted on the first rising edge with rst low.

Verification
REQ-036 Store 001_0010011 accepted -> next cycle write_en=1, wr_addr=3 (MEM_HEIGHT=16), other outputs 0.
REQ-037 Load 010_0000101 -> req_vld=1, rd_addr=5 one cycle; instr_ready=0 until cycle after rd_ack; rd_ack coincident with req_vld ignored.
REQ-038 Repeat 011_0000011 then acc-internal -> input_valid=accumulate_internal=1 for 4 consecutive cycles, instr_ready low for 3 of them.
REQ-039 Opcode 101 -> illegal=1 one cycle, no command outputs; stop 111 -> done=1 held, instr_ready=0 for 20 cycles with instr_valid high.
REQ-040 rst asserted during WAIT_LOAD and during REPEAT -> all outputs 0 immediately (asynchronous), next instruction after release executes normally.
